data_stream_buffer: RTL and testbench

Parametrised multi-channel stream buffer that succeeds the single-lane `template` datapath block: it accepts CHANNELS lanes of DATA_WIDTH-bit samples per beat over a valid/ready handshake, stores up to DEPTH beats and presents them in order on a registered, first-word-fall-through output. It sits between a data-interface producer and a result-interface consumer. A run-time-fixed MODE selects backpressure or drop-on-full behaviour, and the block reports occupancy and statistics.

---
 rtl/data_stream_buffer.sv | 175 +++++++++++++++++
 tb/tb_data_stream_buffer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_stream_buffer.sv
// -----------------------------------------------------------------------------
// data_stream_buffer
//
// Multi-channel stream buffer. Each beat carries CHANNELS lanes of DATA_WIDTH
// bits, with channel 0 in the LSBs. Up to DEPTH beats are stored. They are
// presented in order on a first-word-fall-through output. MODE selects
// backpressure (0) or drop-on-full (1) on the input side.
//
// Optional feature macro: DATA_STREAM_BUFFER_PEAK_EN
//   When defined, the peak_level port and its tracking register are present.
//
// Ports:
//   clk           in   single clock, rising edge
//   reset         in   synchronous, active-high
//   input_data    in   write beat (CHANNELS*DATA_WIDTH)
//   input_valid   in   producer has a beat
//   input_ready   out  buffer accepts a beat
//   output_data   out  head-of-buffer beat
//   output_valid  out  output_data valid
//   output_ready  in   consumer takes the beat
//   level         out  beats stored
//   almost_full   out  level >= ALMOST_FULL_LEVEL
//   drop_count    out  beats discarded while full (MODE 1), saturating
//   clear_stats   in   synchronous clear of drop_count / peak_level
//   peak_level    out  maximum level since reset/clear (macro only)
// -----------------------------------------------------------------------------
module data_stream_buffer #(
    parameter int DATA_WIDTH        = 16,
    parameter int CHANNELS          = 4,
    parameter int DEPTH             = 8,
    parameter int ALMOST_FULL_LEVEL = 6,
    parameter int MODE              = 0,
    localparam int LW               = $clog2(DEPTH + 1),
    localparam int BW               = CHANNELS * DATA_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [BW-1:0] input_data,
    input  logic          input_valid,
    output logic          input_ready,
    output logic [BW-1:0] output_data,
    output logic          output_valid,
    input  logic          output_ready,
    output logic [LW-1:0] level,
    output logic          almost_full,
    output logic [15:0]   drop_count,
    input  logic          clear_stats
`ifdef DATA_STREAM_BUFFER_PEAK_EN
    ,
    output logic [LW-1:0] peak_level
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [BW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [LW-1:0] level_next_s;
    logic          input_ready_r;
    logic          output_valid_r;
    logic          almost_full_r;
    logic [15:0]   drop_count_r;
    logic          push_s;
    logic          pop_s;
    logic          drop_s;
    logic          full_s;

    // Pointer increment with wrap from DEPTH-1 back to 0 (DEPTH need not be 2^n).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == PW'(DEPTH - 1)) begin
            r = {PW{1'b0}};
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    // Handshake decode and next occupancy.
    always_comb begin
        full_s = (level_r == LW'(DEPTH));
        pop_s  = output_valid_r & output_ready;
        if (MODE == 1) begin
            // Full with a simultaneous pop frees the head slot, so the beat fits.
            push_s = input_valid & (~full_s | pop_s);
            drop_s = input_valid & full_s & ~pop_s;
        end else begin
            // input_ready is a register, so no output_ready -> input_ready path.
            push_s = input_valid & input_ready_r;
            drop_s = 1'b0;
        end
        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LW'(1);
            2'b01:   level_next_s = level_r - LW'(1);
            default: level_next_s = level_r;
        endcase
    end

    // Control state: pointers, occupancy, status flags and drop statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r       <= {PW{1'b0}};
            rd_ptr_r       <= {PW{1'b0}};
            level_r        <= {LW{1'b0}};
            input_ready_r  <= 1'b1;
            output_valid_r <= 1'b0;
            almost_full_r  <= 1'b0;
            drop_count_r   <= 16'h0000;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            level_r        <= level_next_s;
            output_valid_r <= (level_next_s != {LW{1'b0}});
            almost_full_r  <= (level_next_s >= LW'(ALMOST_FULL_LEVEL));
            if (MODE == 1) begin
                input_ready_r <= 1'b1;
            end else begin
                input_ready_r <= (level_next_s != LW'(DEPTH));
            end
            // Clear wins over a same-cycle drop.
            if (clear_stats) begin
                drop_count_r <= 16'h0000;
            end else if (drop_s && (drop_count_r != 16'hFFFF)) begin
                drop_count_r <= drop_count_r + 16'h0001;
            end else begin
                drop_count_r <= drop_count_r;
            end
        end
    end

    // Beat storage; data is not reset, occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= input_data;
        end
    end

`ifdef DATA_STREAM_BUFFER_PEAK_EN
    logic [LW-1:0] peak_r;

    // Peak occupancy tracker; clear restarts it from the current occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_r <= {LW{1'b0}};
        end else if (clear_stats) begin
            peak_r <= level_next_s;
        end else if (level_next_s > peak_r) begin
            peak_r <= level_next_s;
        end else begin
            peak_r <= peak_r;
        end
    end

    assign peak_level = peak_r;
`endif

    assign input_ready  = input_ready_r;
    assign output_valid = output_valid_r;
    assign level        = level_r;
    assign almost_full  = almost_full_r;
    assign drop_count   = drop_count_r;
    // Head entry only changes on a pop, so it holds while stalled.
    assign output_data  = mem_r[rd_ptr_r];

endmodule

// File: tb/tb_data_stream_buffer.sv
// -----------------------------------------------------------------------------
// Testbench for data_stream_buffer. It uses two instances: u0 runs in MODE 0
// (backpressure) and u1 runs in MODE 1 (drop-on-full). Flag behaviour is
// checked against vector tables. Data ordering is checked by per-instance
// scoreboards.
// -----------------------------------------------------------------------------
module tb_data_stream_buffer;

    localparam int DW = 8;
    localparam int CH = 2;
    localparam int DP = 4;
    localparam int AF = 3;
    localparam int LW = $clog2(DP + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;

    logic [15:0]   in_data0 = 16'h0000, in_data1 = 16'h0000;
    logic          in_valid0 = 1'b0, in_valid1 = 1'b0;
    logic          out_ready0 = 1'b0, out_ready1 = 1'b0;
    logic          clr0 = 1'b0, clr1 = 1'b0;
    logic          in_ready0, in_ready1;
    logic [15:0]   out_data0, out_data1;
    logic          out_valid0, out_valid1;
    logic [LW-1:0] level0, level1;
    logic          af0, af1;
    logic [15:0]   drop0, drop1;
`ifdef DATA_STREAM_BUFFER_PEAK_EN
    logic [LW-1:0] peak0, peak1;
`endif

    int checks = 0;
    int failures = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int          mlev1 = 0;

    typedef struct {
        logic        vld;
        logic [15:0] data;
        logic        ordy;
        logic        clr;
        int          lvl;
        logic        ir;
        logic        ov;
        logic        af;
        int          drop;
    } vec_t;

    vec_t v0[12];
    vec_t v1[15];

    always #5 clk = ~clk;

    data_stream_buffer #(.DATA_WIDTH(DW), .CHANNELS(CH), .DEPTH(DP),
                         .ALMOST_FULL_LEVEL(AF), .MODE(0)) u0 (
        .clk(clk), .reset(reset),
        .input_data(in_data0), .input_valid(in_valid0), .input_ready(in_ready0),
        .output_data(out_data0), .output_valid(out_valid0), .output_ready(out_ready0),
        .level(level0), .almost_full(af0), .drop_count(drop0), .clear_stats(clr0)
`ifdef DATA_STREAM_BUFFER_PEAK_EN
        , .peak_level(peak0)
`endif
    );

    data_stream_buffer #(.DATA_WIDTH(DW), .CHANNELS(CH), .DEPTH(DP),
                         .ALMOST_FULL_LEVEL(AF), .MODE(1)) u1 (
        .clk(clk), .reset(reset),
        .input_data(in_data1), .input_valid(in_valid1), .input_ready(in_ready1),
        .output_data(out_data1), .output_valid(out_valid1), .output_ready(out_ready1),
        .level(level1), .almost_full(af1), .drop_count(drop1), .clear_stats(clr1)
`ifdef DATA_STREAM_BUFFER_PEAK_EN
        , .peak_level(peak1)
`endif
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic vld, input logic [15:0] data,
                                input logic ordy, input logic clr, input int lvl,
                                input logic ir, input logic ov, input logic af,
                                input int drop);
        vec_t v;
        v.vld = vld; v.data = data; v.ordy = ordy; v.clr = clr; v.lvl = lvl;
        v.ir = ir; v.ov = ov; v.af = af; v.drop = drop;
        return v;
    endfunction

    // One clock cycle: apply inputs, score handshakes, then sample after the edge.
    task automatic drive(input logic a_v, input logic [15:0] a_d, input logic a_r,
                         input logic a_c, input logic b_v, input logic [15:0] b_d,
                         input logic b_r, input logic b_c);
        logic pop1;
        logic acc1;
        @(negedge clk);
        in_valid0 = a_v; in_data0 = a_d; out_ready0 = a_r; clr0 = a_c;
        in_valid1 = b_v; in_data1 = b_d; out_ready1 = b_r; clr1 = b_c;
        #1;
        // Instance 0: pop the head first, then record any accepted beat.
        if (out_valid0 && a_r) begin
            if (q0.size() == 0) begin
                chk("sb0_unexpected_pop", 1, 0);
            end else begin
                chk("sb0_data", out_data0, q0.pop_front());
            end
        end
        if (a_v && in_ready0) q0.push_back(a_d);
        // Instance 1: acceptance follows the drop-on-full rules from a model level.
        pop1 = (mlev1 > 0) && b_r;
        acc1 = b_v && ((mlev1 < DP) || pop1);
        if (pop1) begin
            chk("sb1_valid", out_valid1, 1);
            if (q1.size() == 0) begin
                chk("sb1_unexpected_pop", 1, 0);
            end else begin
                chk("sb1_data", out_data1, q1.pop_front());
            end
        end
        if (acc1) q1.push_back(b_d);
        mlev1 = mlev1 + (acc1 ? 1 : 0) - (pop1 ? 1 : 0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle0(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        // Backpressure table: single beat, fill past full, then drain.
        v0[0]  = mk(1'b1, 16'h0201, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 0);
        v0[1]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0);
        v0[2]  = mk(1'b1, 16'h0A00, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 0);
        v0[3]  = mk(1'b1, 16'h0A01, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 0);
        v0[4]  = mk(1'b1, 16'h0A02, 1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b1, 0);
        v0[5]  = mk(1'b1, 16'h0A03, 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b1, 0);
        v0[6]  = mk(1'b1, 16'h0A04, 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b1, 0);
        v0[7]  = mk(1'b1, 16'h0A04, 1'b1, 1'b0, 3, 1'b1, 1'b1, 1'b1, 0);
        v0[8]  = mk(1'b1, 16'h0A04, 1'b1, 1'b0, 3, 1'b1, 1'b1, 1'b1, 0);
        v0[9]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b0, 0);
        v0[10] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 0);
        v0[11] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0);

        // Drop-on-full table: fill, overflow, full-with-pop, clear, drain.
        v1[0]  = mk(1'b1, 16'hC000, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 0);
        v1[1]  = mk(1'b1, 16'hC001, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 0);
        v1[2]  = mk(1'b1, 16'hC002, 1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b1, 0);
        v1[3]  = mk(1'b1, 16'hC003, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b1, 0);
        v1[4]  = mk(1'b1, 16'hC004, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b1, 1);
        v1[5]  = mk(1'b1, 16'hC005, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b1, 2);
        v1[6]  = mk(1'b1, 16'hC006, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b1, 3);
        v1[7]  = mk(1'b1, 16'hC007, 1'b1, 1'b0, 4, 1'b1, 1'b1, 1'b1, 3);
        v1[8]  = mk(1'b0, 16'h0000, 1'b0, 1'b1, 4, 1'b1, 1'b1, 1'b1, 0);
        v1[9]  = mk(1'b1, 16'hC008, 1'b0, 1'b1, 4, 1'b1, 1'b1, 1'b1, 0);
        v1[10] = mk(1'b1, 16'hC009, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b1, 1);
        v1[11] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 3, 1'b1, 1'b1, 1'b1, 1);
        v1[12] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1);
        v1[13] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1);
        v1[14] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1);

        // Reset state of both instances.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level0", level0, 0);
        chk("rst_ov0", out_valid0, 0);
        chk("rst_ir0", in_ready0, 1);
        chk("rst_af0", af0, 0);
        chk("rst_ir1", in_ready1, 1);
        chk("rst_drop1", drop1, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(v0[i].vld, v0[i].data, v0[i].ordy, v0[i].clr, 1'b0, 16'h0, 1'b0, 1'b0);
            chk($sformatf("m0_level[%0d]", i), level0, v0[i].lvl);
            chk($sformatf("m0_ready[%0d]", i), in_ready0, v0[i].ir);
            chk($sformatf("m0_valid[%0d]", i), out_valid0, v0[i].ov);
            chk($sformatf("m0_af[%0d]", i), af0, v0[i].af);
            chk($sformatf("m0_drop[%0d]", i), drop0, v0[i].drop);
            if (i == 0) chk("first_beat_data", out_data0, 16'h0201);
        end
        chk("m0_sb_empty", q0.size(), 0);

        // Continuous streaming at one beat per cycle through pointer wrap.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 16'hB000 + 16'(i), 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
            chk($sformatf("stream_level[%0d]", i), level0, 1);
            chk($sformatf("stream_ready[%0d]", i), in_ready0, 1);
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("stream_end_level", level0, 0);
        chk("stream_sb_empty", q0.size(), 0);

        for (int i = 0; i < 15; i++) begin
            drive(1'b0, 16'h0, 1'b0, 1'b0, v1[i].vld, v1[i].data, v1[i].ordy, v1[i].clr);
            chk($sformatf("m1_level[%0d]", i), level1, v1[i].lvl);
            chk($sformatf("m1_ready[%0d]", i), in_ready1, v1[i].ir);
            chk($sformatf("m1_valid[%0d]", i), out_valid1, v1[i].ov);
            chk($sformatf("m1_af[%0d]", i), af1, v1[i].af);
            chk($sformatf("m1_drop[%0d]", i), drop1, v1[i].drop);
        end
        chk("m1_sb_empty", q1.size(), 0);

        // Reset mid-stream: stored beats must never appear afterwards.
        drive(1'b1, 16'hE000, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        drive(1'b1, 16'hE001, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        drive(1'b1, 16'hE002, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("pre_rst_level0", level0, 3);
        @(negedge clk);
        reset = 1'b1;
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_level0", level0, 0);
        chk("mid_rst_ov0", out_valid0, 0);
        chk("mid_rst_ir0", in_ready0, 1);
        chk("mid_rst_drop1", drop1, 0);
        q0.delete();
        q1.delete();
        mlev1 = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
            chk($sformatf("post_rst_ov0[%0d]", i), out_valid0, 0);
        end
        drive(1'b1, 16'hF000, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("post_rst_head", out_data0, 16'hF000);
        drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("post_rst_level0", level0, 0);

`ifdef DATA_STREAM_BUFFER_PEAK_EN
        // Peak: fill to 3, drain, then clear while empty.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("peak_rst", peak0, 0);
        q0.delete(); q1.delete(); mlev1 = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1, 16'hD000 + 16'(i), 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("peak_after_drain_level", level0, 0);
        chk("peak_after_drain", peak0, 3);
        drive(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("peak_after_clear", peak0, 0);
`endif

        idle0(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
